// File: rtl/ps2_host_transmitter_pkg.sv
// Shared encodings, command bytes and frame builder for the PS/2 host transmitter.
package ps2_host_transmitter_pkg;

    localparam logic [2:0] PS2_TX_IDLE      = 3'd0;
    localparam logic [2:0] PS2_TX_INHIBIT   = 3'd1;
    localparam logic [2:0] PS2_TX_REQ       = 3'd2;
    localparam logic [2:0] PS2_TX_SEND      = 3'd3;
    localparam logic [2:0] PS2_TX_ACK       = 3'd4;
    localparam logic [2:0] PS2_TX_WAIT_IDLE = 3'd5;
    localparam logic [2:0] PS2_TX_ERR       = 3'd6;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    localparam int unsigned TimerWidth = 20;
    localparam int unsigned FrameBits  = 10;

    typedef enum logic [2:0] {
        StIdle     = PS2_TX_IDLE,
        StInhibit  = PS2_TX_INHIBIT,
        StReq      = PS2_TX_REQ,
        StSend     = PS2_TX_SEND,
        StAck      = PS2_TX_ACK,
        StWaitIdle = PS2_TX_WAIT_IDLE,
        StErr      = PS2_TX_ERR
    } tx_state_e;

    // Bit 0 goes out first: d0..d7, odd parity, stop.
    function automatic logic [FrameBits-1:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 pin with a registered falling-edge strobe.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic level,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;
    logic fall_q, fall_d;

    always_comb begin
        s1_d   = line_in;
        s2_d   = s1_q;
        prev_d = s2_q;
        fall_d = prev_q & ~s2_q;
    end

    // Stages reset to 1 so a released line does not look like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
            fall_q <= fall_d;
        end
    end

    assign level = s2_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device transmitter: request-to-send, framed byte, acknowledge check, timeouts.
module ps2_host_transmitter
    import ps2_host_transmitter_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned START_TIMEOUT  = 750000,
    parameter int unsigned XFER_TIMEOUT   = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam logic [TimerWidth-1:0] InhibitLast = TimerWidth'(INHIBIT_CYCLES - 1);
    localparam logic [TimerWidth-1:0] StartLast   = TimerWidth'(START_TIMEOUT - 1);
    localparam logic [TimerWidth-1:0] XferLast    = TimerWidth'(XFER_TIMEOUT - 1);
    localparam logic [TimerWidth-1:0] TimerOne    = TimerWidth'(1);
    localparam logic [3:0]            LastEdge    = 4'd9;

    logic clk_level, clk_fall, data_level, data_fall_unused;

    tx_state_e             state_q, state_d;
    logic [TimerWidth-1:0] timer_q, timer_d;
    logic [3:0]            edge_cnt_q, edge_cnt_d;
    logic [FrameBits-1:0]  shreg_q, shreg_d;
    logic clk_oe_q, clk_oe_d;
    logic data_oe_q, data_oe_d;
    logic ready_q, ready_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic error_q, error_d;

    ps2_line_sync u_clk_sync (
        .clk     (clk),
        .rst     (rst),
        .line_in (ps2_clk_in),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk     (clk),
        .rst     (rst),
        .line_in (ps2_data_in),
        .level   (data_level),
        .fall    (data_fall_unused)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + TimerOne;
        edge_cnt_d = edge_cnt_q;
        shreg_d    = shreg_q;
        data_oe_d  = data_oe_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                timer_d    = '0;
                edge_cnt_d = 4'd0;
                if (tx_valid && ready_q) begin
                    state_d = StInhibit;
                    shreg_d = ps2_frame(tx_data);
                end
            end
            StInhibit: begin
                if (timer_q >= InhibitLast) state_d = StReq;
            end
            StReq: begin
                state_d = StSend;
            end
            StSend: begin
                // Timeouts take priority over a coincident clock edge.
                if (edge_cnt_q == 4'd0 && timer_q >= StartLast) begin
                    state_d = StErr;
                end else if (edge_cnt_q != 4'd0 && timer_q >= XferLast) begin
                    state_d = StErr;
                end else if (clk_fall) begin
                    data_oe_d  = ~shreg_q[0];
                    shreg_d    = {1'b0, shreg_q[FrameBits-1:1]};
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    if (edge_cnt_q == 4'd0) timer_d = '0;
                    if (edge_cnt_q == LastEdge) state_d = StAck;
                end
            end
            StAck: begin
                if (timer_q >= XferLast) begin
                    state_d = StErr;
                end else if (clk_fall) begin
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    state_d    = data_level ? StErr : StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (clk_level && data_level) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StErr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The transfer timeout keeps counting across SEND -> ACK.
        if (state_d != state_q && !(state_q == StSend && state_d == StAck)) timer_d = '0;

        if (state_d != StSend) data_oe_d = (state_d == StReq);
        clk_oe_d = (state_d == StInhibit) || (state_d == StReq);
        ready_d  = (state_d == StIdle) && !done_d;
        busy_d   = (state_d != StIdle);
        error_d  = (state_d == StErr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            edge_cnt_q <= 4'd0;
            shreg_q    <= '0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            edge_cnt_q <= edge_cnt_d;
            shreg_q    <= shreg_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_ready    = ready_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed bench for ps2_host_transmitter with a simple PS/2 device model.
module tb_ps2_host_transmitter;
    import ps2_host_transmitter_pkg::*;

    localparam int unsigned InhibitCycles = 100;
    localparam int unsigned StartTimeout  = 2000;
    localparam int unsigned XferTimeout   = 2000;
    localparam int Half = 20;

    logic clk = 1'b0;
    logic rst, tx_valid, tx_ready;
    logic [7:0] tx_data;
    logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic tx_busy, tx_done, tx_error;
    logic dev_clk, dev_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0, acc_cnt = 0;
    int last_done_cyc = 0, last_acc_cyc = 0;

    always #5 clk = ~clk;

    // Open-drain lines: low if either side pulls.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_transmitter #(
        .INHIBIT_CYCLES (InhibitCycles),
        .START_TIMEOUT  (StartTimeout),
        .XFER_TIMEOUT   (XferTimeout)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_done === 1'b1) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
        if (tx_error === 1'b1) err_cnt <= err_cnt + 1;
        if (tx_valid === 1'b1 && tx_ready === 1'b1 && rst === 1'b0) begin
            acc_cnt      <= acc_cnt + 1;
            last_acc_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pulse(input bit want_done, input int limit, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            seen = want_done ? (tx_done === 1'b1) : (tx_error === 1'b1);
        end
        check(tag, seen, 1);
    endtask

    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        check("ready before accept", tx_ready, 1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    // Waits for the start bit, then clocks out `edges` bits, sampling late in each low phase.
    task automatic device_frame(input int edges, output logic [10:0] bits);
        int n;
        n = 0;
        bits = '0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("send state reached", n < 5000, 1);
        repeat (5) @(negedge clk);
        bits[0] = ps2_data_in;
        for (int i = 1; i <= edges; i++) begin
            dev_clk = 1'b0;
            repeat (Half) @(negedge clk);
            bits[i] = ps2_data_in;
            dev_clk = 1'b1;
            repeat (Half) @(negedge clk);
        end
    endtask

    task automatic device_ack(input bit ack_low);
        dev_data = ack_low ? 1'b0 : 1'b1;
        repeat (Half) @(negedge clk);
        dev_clk = 1'b0;
    endtask

    task automatic device_release();
        repeat (Half) @(negedge clk);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [10:0] bits;
        int base_done, base_err, base_acc, n;

        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; dev_clk = 1'b1; dev_data = 1'b1;
        repeat (3) @(negedge clk);
        check("reset clk_oe", ps2_clk_oe, 0);
        check("reset data_oe", ps2_data_oe, 0);
        check("reset ready", tx_ready, 1);
        check("reset busy", tx_busy, 0);
        check("reset done", tx_done, 0);
        check("reset error", tx_error, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: 8'hED with acknowledge, plus request-sequence timing.
        base_done = done_cnt; base_err = err_cnt;
        send_byte(PS2_CMD_SET_LEDS);
        check("busy after accept", tx_busy, 1);
        check("ready after accept", tx_ready, 0);
        n = 0;
        @(negedge clk);
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("inhibit cycles", n, 100);
        check("req clk_oe", ps2_clk_oe, 1);
        check("req data_oe", ps2_data_oe, 1);
        @(negedge clk);
        check("send clk released", ps2_clk_oe, 0);
        check("send start bit", ps2_data_oe, 1);
        device_frame(10, bits);
        check("ED frame bits", bits, {1'b1, 1'b1, 8'hED, 1'b0});
        device_ack(1'b1);
        device_release();
        wait_pulse(1'b1, 40, "ED done seen");
        repeat (3) @(negedge clk);
        check("ED done count", done_cnt - base_done, 1);
        check("ED error count", err_cnt - base_err, 0);

        // 2: 8'hF4, parity 0.
        base_done = done_cnt;
        send_byte(PS2_CMD_ENABLE);
        device_frame(10, bits);
        check("F4 frame bits", bits, {1'b1, 1'b0, 8'hF4, 1'b0});
        device_ack(1'b1);
        device_release();
        wait_pulse(1'b1, 40, "F4 done seen");
        repeat (3) @(negedge clk);
        check("F4 done count", done_cnt - base_done, 1);

        // 3: 8'h00, device leaves data high on the acknowledge edge.
        base_done = done_cnt; base_err = err_cnt;
        send_byte(8'h00);
        device_frame(10, bits);
        check("00 frame bits", bits, {1'b1, 1'b1, 8'h00, 1'b0});
        device_ack(1'b0);
        wait_pulse(1'b0, 20, "nack error seen");
        @(negedge clk);
        check("nack clk_oe", ps2_clk_oe, 0);
        check("nack data_oe", ps2_data_oe, 0);
        check("nack ready", tx_ready, 1);
        device_release();
        repeat (5) @(negedge clk);
        check("nack error count", err_cnt - base_err, 1);
        check("nack done count", done_cnt - base_done, 0);

        // 4: 8'hFF, device never clocks.
        base_done = done_cnt; base_err = err_cnt;
        send_byte(PS2_CMD_RESET);
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (tx_error === 1'b1) break;
        end
        check("start timeout latency", (n >= 2100 && n <= 2104), 1);
        @(negedge clk);
        check("timeout clk_oe", ps2_clk_oe, 0);
        check("timeout data_oe", ps2_data_oe, 0);
        repeat (3) @(negedge clk);
        check("timeout error count", err_cnt - base_err, 1);
        check("timeout done count", done_cnt - base_done, 0);

        // 5: reset after falling edge 4, then a clean send.
        base_done = done_cnt; base_err = err_cnt;
        send_byte(PS2_CMD_SET_LEDS);
        device_frame(3, bits);
        dev_clk = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst mid clk_oe", ps2_clk_oe, 0);
        check("rst mid data_oe", ps2_data_oe, 0);
        check("rst mid ready", tx_ready, 1);
        rst = 1'b0;
        dev_clk = 1'b1;
        repeat (10) @(negedge clk);
        check("rst mid done count", done_cnt - base_done, 0);
        check("rst mid error count", err_cnt - base_err, 0);
        send_byte(PS2_CMD_ENABLE);
        device_frame(10, bits);
        check("post-rst F4 bits", bits, {1'b1, 1'b0, 8'hF4, 1'b0});
        device_ack(1'b1);
        device_release();
        wait_pulse(1'b1, 40, "post-rst done seen");

        // 6: tx_valid held high with 8'h01.
        repeat (3) @(negedge clk);
        base_acc = acc_cnt; base_done = done_cnt;
        tx_valid = 1'b1;
        tx_data  = 8'h01;
        for (int t = 0; t < 2; t++) begin
            device_frame(10, bits);
            if (t == 1) check("gap after done", (last_acc_cyc - last_done_cyc) >= 1, 1);
            check("01 frame bits", bits, {1'b1, 1'b0, 8'h01, 1'b0});
            device_ack(1'b1);
            device_release();
            wait_pulse(1'b1, 40, "01 done seen");
            if (t == 1) tx_valid = 1'b0;
            check("accepts per transfer", acc_cnt - base_acc, t + 1);
        end
        repeat (5) @(negedge clk);
        check("held valid total accepts", acc_cnt - base_acc, 2);
        check("held valid done count", done_cnt - base_done, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
